// File: rtl/bubble_sort_engine.sv
// In-place bubble sorter for an external sync-read RAM.
// Registered RAM-side outputs show the value that belongs to the current state:
// they are loaded from the next state on the edge that enters that state.
// Passes exit early as soon as one pass makes no swap.
module bubble_sort_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int SWAP_W = 16
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              s_start,
  input  logic [ADDR_W:0]   s_n,
  input  logic              s_desc,
  output logic [ADDR_W-1:0] s_raddr,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_waddr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_busy,
  output logic              s_done,
  output logic [SWAP_W-1:0] s_swaps,
  output logic [ADDR_W:0]   s_passes
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH = CW'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] ONE   = CW'(1);
  localparam logic [ADDR_W:0] TWO   = CW'(2);

  typedef enum logic [3:0] {
    IDLE, RD0, RD1, CAP, CMP, WR0, WR1, NEXT, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic              desc_q, desc_d;
  logic [ADDR_W:0]   i_q, i_d;
  logic [ADDR_W:0]   pass_q, pass_d;
  logic              swapped_q, swapped_d;
  logic [DATA_W-1:0] t1, t2;
  logic              clr_stats, inc_swaps, inc_passes;

  logic [ADDR_W:0]   n_clamp;
  logic              do_swap, more_pairs, last_pass;

  // Counts above the RAM depth sort the whole RAM.
  assign n_clamp    = (s_n > DEPTH) ? DEPTH : s_n;
  // Strict compare keeps equal elements in place, so the sort is stable.
  assign do_swap    = desc_q ? (t1 < t2) : (t1 > t2);
  // Extra top bit keeps n-1-pass from wrapping for every n >= 2.
  assign more_pairs = (i_q + ONE) < (n_q - ONE - pass_q);
  assign last_pass  = (pass_q + ONE) == (n_q - ONE);
  assign s_busy     = (state_q != IDLE);

  // Next-state and control decode for the sort sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d    = state_q;
    n_d        = n_q;
    desc_d     = desc_q;
    i_d        = i_q;
    pass_d     = pass_q;
    swapped_d  = swapped_q;
    clr_stats  = 1'b0;
    inc_swaps  = 1'b0;
    inc_passes = 1'b0;
    unique case (state_q)
      IDLE: if (s_start) begin
        n_d       = n_clamp;
        desc_d    = s_desc;
        i_d       = '0;
        pass_d    = '0;
        swapped_d = 1'b0;
        clr_stats = 1'b1;
        state_d   = (n_clamp < TWO) ? DONE : RD0;
      end
      RD0: state_d = RD1;
      RD1: state_d = CAP;
      CAP: state_d = CMP;
      CMP: state_d = do_swap ? WR0 : NEXT;
      WR0: state_d = WR1;
      WR1: begin
        swapped_d = 1'b1;
        inc_swaps = 1'b1;
        state_d   = NEXT;
      end
      NEXT: begin
        if (more_pairs) begin
          i_d     = i_q + ONE;
          state_d = RD0;
        end else begin
          inc_passes = 1'b1;
          if (!swapped_q || last_pass) begin
            state_d = DONE;
          end else begin
            pass_d    = pass_q + ONE;
            i_d       = '0;
            swapped_d = 1'b0;
            state_d   = RD0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered RAM-port/status outputs.
  always_ff @(posedge s_clk) begin
    // NOTE: reset is synchronous: it only takes effect on a rising clock edge.
    if (s_rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      desc_q    <= 1'b0;
      i_q       <= '0;
      pass_q    <= '0;
      swapped_q <= 1'b0;
      t1        <= '0;
      t2        <= '0;
      s_raddr   <= '0;
      s_we      <= 1'b0;
      s_waddr   <= '0;
      s_wdata   <= '0;
      s_done    <= 1'b0;
      s_swaps   <= '0;
      s_passes  <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      desc_q    <= desc_d;
      i_q       <= i_d;
      pass_q    <= pass_d;
      swapped_q <= swapped_d;

      if (state_q == RD1) t1 <= s_rdata;
      if (state_q == CAP) t2 <= s_rdata;

      // Address is presented during RD0/RD1 so data arrives in RD1/CAP.
      if (state_d == RD0) s_raddr <= i_d[ADDR_W-1:0];
      if (state_d == RD1) s_raddr <= i_d[ADDR_W-1:0] + ADDR_W'(1);

      s_we <= (state_d == WR0) || (state_d == WR1);
      if (state_d == WR0) begin
        s_waddr <= i_q[ADDR_W-1:0];
        s_wdata <= t2;
      end
      if (state_d == WR1) begin
        s_waddr <= i_q[ADDR_W-1:0] + ADDR_W'(1);
        s_wdata <= t1;
      end

      s_done <= (state_q == DONE);

      if (clr_stats) begin
        s_swaps  <= '0;
        s_passes <= '0;
      end else begin
        if (inc_swaps && (s_swaps != '1)) s_swaps <= s_swaps + SWAP_W'(1);
        if (inc_passes) s_passes <= s_passes + ONE;
      end
    end
  end

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Self-checking bench for bubble_sort_engine: table vectors, reset-in-write
// sequence, and randomized full-depth sorts against an array-level model.
module tb_bubble_sort_engine;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int SWAP_W = 16;
  localparam int DEPTH  = 32;
  localparam int CW     = ADDR_W + 1;

  logic              clk;
  logic              s_rst, s_start, s_desc;
  logic [ADDR_W:0]   s_n;
  logic [ADDR_W-1:0] s_raddr, s_waddr;
  logic [DATA_W-1:0] s_rdata, s_wdata;
  logic              s_we, s_busy, s_done;
  logic [SWAP_W-1:0] s_swaps;
  logic [ADDR_W:0]   s_passes;

  int compared   = 0;
  int mismatched = 0;

  bubble_sort_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SWAP_W(SWAP_W)) dut (
    .s_clk(clk), .s_rst(s_rst), .s_start(s_start), .s_n(s_n), .s_desc(s_desc),
    .s_raddr(s_raddr), .s_rdata(s_rdata), .s_we(s_we), .s_waddr(s_waddr),
    .s_wdata(s_wdata), .s_busy(s_busy), .s_done(s_done), .s_swaps(s_swaps),
    .s_passes(s_passes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sync-read RAM with a bench-side load port used only while the DUT is idle.
  logic [DATA_W-1:0] mem [DEPTH];
  logic              ld_we = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;
  int                wcount = 0;

  always @(posedge clk) begin
    s_rdata <= mem[s_raddr];
    if (s_we) begin
      mem[s_waddr] <= s_wdata;
      wcount <= wcount + 1;
    end else if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input logic [DATA_W-1:0] d [DEPTH]);
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      ld_we = 1'b1; ld_addr = ADDR_W'(k); ld_data = d[k];
    end
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  // Array-level reference: bubble sort with early exit, plus the cycle cost
  // implied by 5 cycles per compare, 2 more per swap, and the done delay.
  task automatic model(input logic [DATA_W-1:0] d [DEPTH], input int n, input bit desc,
                       output logic [DATA_W-1:0] r [DEPTH], output int sw,
                       output int ps, output int lat);
    int nn, cmp;
    logic [DATA_W-1:0] tmp;
    nn = (n > DEPTH) ? DEPTH : n;
    r = d; sw = 0; ps = 0; cmp = 0;
    if (nn >= 2) begin
      for (int p = 0; p < nn - 1; p++) begin
        bit any;
        any = 1'b0;
        for (int j = 0; j < nn - 1 - p; j++) begin
          cmp++;
          if (desc ? (r[j] < r[j+1]) : (r[j] > r[j+1])) begin
            tmp = r[j]; r[j] = r[j+1]; r[j+1] = tmp;
            sw++; any = 1'b1;
          end
        end
        ps++;
        if (!any) break;
      end
    end
    lat = (nn < 2) ? 1 : 5 * cmp + 2 * sw + 1;
  endtask

  // Start one run, wait (bounded) for s_done; optional start/n/desc noise mid-run.
  task automatic run(input int n, input bit desc, input bit noise,
                     output int lat, output int writes, output bit seen);
    int w0;
    w0 = wcount;
    @(negedge clk);
    s_n = CW'(n); s_desc = desc; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    lat = 0; seen = 1'b0;
    while (lat < 20000) begin
      @(posedge clk); lat++; #1;
      s_start = 1'b0;
      if (s_done) begin seen = 1'b1; break; end
      if (noise && s_busy && (lat % 50 == 7)) begin
        s_start = 1'b1; s_n = CW'($urandom); s_desc = ~s_desc;
      end
    end
    writes = wcount - w0;
  endtask

  task automatic full_check(input string tag, input logic [DATA_W-1:0] d [DEPTH],
                            input int n, input bit desc, input bit noise);
    logic [DATA_W-1:0] r [DEPTH];
    int sw, ps, lat, alat, wr;
    bit seen;
    int bad;
    model(d, n, desc, r, sw, ps, lat);
    load(d);
    run(n, desc, noise, alat, wr, seen);
    check({tag, " done_seen"}, int'(seen), 1);
    check({tag, " latency"}, alat, lat);
    check({tag, " swaps"}, int'(s_swaps), sw);
    check({tag, " passes"}, int'(s_passes), ps);
    check({tag, " writes"}, wr, 2 * sw);
    check({tag, " busy_at_done"}, int'(s_busy), 0);
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, int'(s_done), 0);
    bad = 0;
    for (int k = 0; k < DEPTH; k++) if (mem[k] !== r[k]) bad++;
    check({tag, " ram_words_wrong"}, bad, 0);
  endtask

  typedef struct {
    string            name;
    int               n;
    bit               desc;
    logic [0:3][7:0]  d;
    logic [0:3][7:0]  e;
    int               sw;
    int               ps;
    int               lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [DATA_W-1:0] d [DEPTH];
    logic [DATA_W-1:0] r [DEPTH];
    int sw, ps, lat, alat, wr, bad, w0, waited;
    bit seen;

    vecs[0] = '{"asc_sorted", 4, 1'b0, {8'd1, 8'd2, 8'd3, 8'd4}, {8'd1, 8'd2, 8'd3, 8'd4}, 0, 1, 16};
    vecs[1] = '{"asc_rev",    4, 1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd1, 8'd2, 8'd3, 8'd4}, 6, 3, -1};
    vecs[2] = '{"desc_rev",   4, 1'b1, {8'd1, 8'd2, 8'd3, 8'd4}, {8'd4, 8'd3, 8'd2, 8'd1}, 6, 3, -1};
    vecs[3] = '{"asc_dup",    3, 1'b0, {8'd2, 8'd2, 8'd1, 8'd9}, {8'd1, 8'd2, 8'd2, 8'd9}, 2, 2, -1};
    vecs[4] = '{"n0",         0, 1'b0, {8'd5, 8'd6, 8'd7, 8'd8}, {8'd5, 8'd6, 8'd7, 8'd8}, 0, 0, 1};
    vecs[5] = '{"n1",         1, 1'b0, {8'd8, 8'd6, 8'd7, 8'd5}, {8'd8, 8'd6, 8'd7, 8'd5}, 0, 0, 1};

    s_rst = 1'b1; s_start = 1'b0; s_n = '0; s_desc = 1'b0;
    for (int k = 0; k < DEPTH; k++) mem[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(s_busy), 0);
    check("rst_done", int'(s_done), 0);
    check("rst_we", int'(s_we), 0);
    check("rst_raddr", int'(s_raddr), 0);
    check("rst_swaps", int'(s_swaps), 0);
    check("rst_passes", int'(s_passes), 0);
    @(negedge clk);
    s_rst = 1'b0;

    // Hand-computed vectors: result words, stats, writes and selected latencies.
    foreach (vecs[v]) begin
      for (int k = 0; k < DEPTH; k++) d[k] = 8'(k + 100);
      for (int k = 0; k < 4; k++) d[k] = vecs[v].d[k];
      load(d);
      run(vecs[v].n, vecs[v].desc, 1'b0, alat, wr, seen);
      check({vecs[v].name, " done_seen"}, int'(seen), 1);
      if (vecs[v].lat >= 0) check({vecs[v].name, " latency"}, alat, vecs[v].lat);
      check({vecs[v].name, " swaps"}, int'(s_swaps), vecs[v].sw);
      check({vecs[v].name, " passes"}, int'(s_passes), vecs[v].ps);
      check({vecs[v].name, " writes"}, wr, 2 * vecs[v].sw);
      for (int k = 0; k < 4; k++)
        check({vecs[v].name, $sformatf(" ram[%0d]", k)}, int'(mem[k]), int'(vecs[v].e[k]));
      @(posedge clk); #1;
      check({vecs[v].name, " done_one_cycle"}, int'(s_done), 0);
    end

    // Reset while the first write of a swap is on the RAM port.
    for (int k = 0; k < DEPTH; k++) d[k] = 8'(DEPTH - k);
    load(d);
    @(negedge clk);
    s_n = CW'(DEPTH); s_desc = 1'b0; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    waited = 0;
    while (!s_we && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    check("rst_wr0 we_reached", int'(s_we), 1);
    w0 = wcount;
    s_rst = 1'b1;
    @(posedge clk); #1;
    check("rst_wr0 we_next", int'(s_we), 0);
    check("rst_wr0 busy_next", int'(s_busy), 0);
    @(negedge clk);
    s_rst = 1'b0;
    check("rst_wr0 one_write", wcount - w0, 1);
    for (int k = 0; k < DEPTH; k++) d[k] = mem[k];
    full_check("after_rst", d, DEPTH, 1'b0, 1'b0);

    // Randomized runs, full depth and clamped counts, with mid-run noise.
    for (int t = 0; t < 6; t++) begin
      int n;
      bit desc;
      for (int k = 0; k < DEPTH; k++) d[k] = 8'($urandom_range(0, (t % 2 == 0) ? 15 : 255));
      case (t)
        0, 1:    n = DEPTH;
        2:       n = 63;
        default: n = $urandom_range(2, DEPTH - 1);
      endcase
      desc = 1'($urandom);
      full_check($sformatf("rand%0d_n%0d_d%0d", t, n, desc), d, n, desc, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
